gbuff_burst: RTL and testbench
==============================

GBUFF_BURST -- requirements
Module: gbuff_burst

Interface
REQ-001 Parameter ADDR_BITS, default 8, word address width; DEPTH = 2**ADDR_BITS words.
REQ-002 Parameter DATA_BITS, default 32, word width, multiple of 8; NB = DATA_BITS/8 byte lanes.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 wr_en  in  1  random-access write request.
REQ-006 byte_en  in  NB  per-byte write mask for wr_en.
REQ-007 rd_en  in  1  random-access read request.
REQ-008 index  in  ADDR_BITS  random-access word address.
REQ-009 data_in  in  DATA_BITS  random-access write data.
REQ-010 data_out  out  DATA_BITS  random-access read data.
REQ-011 rd_valid  out  1  data_out valid this cycle.
REQ-012 burst_start  in  1  one-cycle burst launch pulse.
REQ-013 burst_dir  in  1  0 = stream-in write burst, 1 = stream-out read burst.
REQ-014 burst_base  in  ADDR_BITS  first burst address.
REQ-015 burst_len  in  ADDR_BITS+1  word count, legal 1..DEPTH.
REQ-016 s_valid / s_data / s_ready  in / in DATA_BITS / out  write-burst stream.
REQ-017 m_valid / m_data / m_ready  out / out DATA_BITS / in  read-burst stream.
REQ-018 busy  out  1  burst in progress; done  out  1  one-cycle pulse at burst end; err  out  1  one-cycle pulse on rejected request.

Function
REQ-019 Random write: wr_en high, busy low -> each byte lane with byte_en set updated at index on that edge; other lanes unchanged.
REQ-020 Random read: rd_en high, busy low -> data_out = mem[index], rd_valid high, exactly 1 cycle later; data_out holds its value when rd_valid low.
REQ-021 wr_en and rd_en same cycle, same index: read returns pre-write data (read-first); write still performed.
REQ-022 State machine IDLE, WBURST, RBURST, DONE; busy high in WBURST/RBURST.
REQ-023 IDLE + burst_start with burst_len in 1..DEPTH -> WBURST (dir 0) or RBURST (dir 1); base, len latched; address counter = base, remaining = len.
REQ-024 burst_start with burst_len = 0 or > DEPTH: no transition, err pulse next cycle.
REQ-025 burst_start while busy: ignored, err pulse; running burst unaffected.
REQ-026 wr_en or rd_en while busy: ignored, no rd_valid, err pulse.
REQ-027 WBURST: s_ready high in WBURST; each s_valid&&s_ready beat writes full word at counter, counter+1, remaining-1; last beat -> DONE.
REQ-028 RBURST: memory read issued only when 2-entry output buffer has space; m_valid high when buffer non-empty; m_data stable while m_valid && !m_ready; sustains one beat per cycle with m_ready held high.
REQ-029 RBURST -> DONE after final beat accepted (m_valid && m_ready) and buffer empty.
REQ-030 Address counter wraps DEPTH-1 -> 0.
REQ-031 DONE: done high for that one cycle, busy low, -> IDLE next cycle.
REQ-032 s_ready low and m_valid low outside their burst state.

Reset
REQ-033 rst low: state IDLE; data_out, rd_valid, s_ready, m_valid, m_data, busy, done, err = 0; counters and output buffer cleared, immediately (asynchronous).
REQ-034 Memory contents not reset; reset mid-burst aborts it with no done pulse; words already written stay written.

Structure
REQ-035 Shared package holds state encoding constants (IDLE, WBURST, RBURST, DONE) and burst_dir encodings.
REQ-036 One sub-module gbuff_skid2: 2-entry valid/ready output buffer used by RBURST.
REQ-037 Storage is a single DEPTH x DATA_BITS array, one synchronous read port, one write port.

Verification
REQ-038 Byte mask: write 0xAABBCCDD at 5 with byte_en=1111, then 0x11223344 with byte_en=0101; rd_en at 5 -> data_out 0xAA22CC44 one cycle later.
REQ-039 Collision: mem[3]=0x1, wr_en+rd_en at 3 with 0x2 -> data_out 0x1; next read -> 0x2.
REQ-040 Wrap write burst: base 254, len 4, beats 0x10..0x13 with s_valid gaps -> addresses 254,255,0,1 hold 0x10..0x13; done one pulse after last beat.
REQ-041 Read burst backpressure: base 254, len 4, m_ready toggled 1,0,0,1,... -> m_data sequence 0x10,0x11,0x12,0x13 exactly once each, stable while stalled.
REQ-042 Rejects: burst_len 0 -> err, busy stays 0; rd_en during burst -> err, no rd_valid; burst_start during burst -> err, burst completes normally.
REQ-043 Reset mid-burst: rst low after 2 of 4 write beats -> all outputs 0 immediately, IDLE, first 2 words retained, no done.

Source files
------------

// File: rtl/gbuff_burst_pkg.sv
// Shared definitions for the burst-capable global buffer: FSM encoding and burst direction codes.
package gbuff_burst_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WBURST = 2'd1,
      RBURST = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic DIR_WRITE = 1'b0;
   localparam logic DIR_READ  = 1'b1;

endpackage

// File: rtl/gbuff_skid2.sv
// Two-entry valid/ready output buffer; head entry drives out_data directly so it stays stable while stalled.
module gbuff_skid2 #(
   parameter int unsigned DATA_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [DATA_BITS-1:0] in_data,
   output logic                 out_valid,
   output logic [DATA_BITS-1:0] out_data,
   input  logic                 out_ready,
   output logic [1:0]           count
);

   logic [DATA_BITS-1:0] spare;
   logic                 pop;

   assign pop = out_valid && out_ready;

   // Producer never pushes into a full buffer; the caller accounts for in-flight reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         spare     <= '0;
         count     <= 2'd0;
      end else begin
         case ({in_valid, pop})
            2'b10: begin
               if (count == 2'd0) out_data <= in_data;
               else               spare    <= in_data;
               count     <= count + 2'd1;
               out_valid <= 1'b1;
            end
            2'b01: begin
               out_data  <= spare;
               count     <= count - 2'd1;
               out_valid <= (count == 2'd2);
            end
            2'b11: begin
               if (count == 2'd1) begin
                  out_data <= in_data;
               end else begin
                  out_data <= spare;
                  spare    <= in_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/gbuff_burst.sv
// Byte-maskable word buffer with random access plus streamed write/read bursts sharing one
// synchronous read port and one write port.
module gbuff_burst
   import gbuff_burst_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned DATA_BITS = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [DATA_BITS/8-1:0] byte_en,
   input  logic                   rd_en,
   input  logic [ADDR_BITS-1:0]   index,
   input  logic [DATA_BITS-1:0]   data_in,
   output logic [DATA_BITS-1:0]   data_out,
   output logic                   rd_valid,
   input  logic                   burst_start,
   input  logic                   burst_dir,
   input  logic [ADDR_BITS-1:0]   burst_base,
   input  logic [ADDR_BITS:0]     burst_len,
   input  logic                   s_valid,
   input  logic [DATA_BITS-1:0]   s_data,
   output logic                   s_ready,
   output logic                   m_valid,
   output logic [DATA_BITS-1:0]   m_data,
   input  logic                   m_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int unsigned NB    = DATA_BITS / 8;
   localparam int unsigned LW    = ADDR_BITS + 1;
   localparam int unsigned DEPTH = 1 << ADDR_BITS;

   logic [DATA_BITS-1:0] mem [DEPTH];

   state_t               state;
   logic [ADDR_BITS-1:0] addr;
   logic [LW-1:0]        remaining;
   logic [LW-1:0]        issue_left;
   logic                 rd_pend;
   logic [DATA_BITS-1:0] rd_q;
   logic [DATA_BITS-1:0] data_hold;
   logic [1:0]           buf_count;

   logic                 wr_acc, rd_acc, rd_issue, pop, space_ok, len_ok, wbeat;
   logic [2:0]           occ;
   logic [NB-1:0]        wr_mask;
   logic [ADDR_BITS-1:0] wr_addr, rd_addr;
   logic [DATA_BITS-1:0] wr_data;

   assign wr_acc   = wr_en && !busy;
   assign rd_acc   = rd_en && !busy;
   assign wbeat    = s_valid && s_ready;
   assign pop      = m_valid && m_ready;
   assign len_ok   = (burst_len != '0) && (burst_len <= LW'(DEPTH));
   // Buffered words plus the read already in flight must leave room, counting a same-cycle pop.
   assign occ      = 3'(buf_count) + 3'(rd_pend);
   assign space_ok = occ < (3'd2 + 3'(pop));
   assign rd_issue = (state == RBURST) && (issue_left != '0) && space_ok;
   assign rd_addr  = (state == RBURST) ? addr : index;
   assign data_out = rd_valid ? rd_q : data_hold;

   always_comb begin
      wr_mask = '0;
      wr_addr = index;
      wr_data = data_in;
      if (wbeat) begin
         wr_mask = '1;
         wr_addr = addr;
         wr_data = s_data;
      end else if (wr_acc) begin
         wr_mask = byte_en;
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < int'(NB); b++) begin
         if (wr_mask[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
   end

   // Single read port; non-blocking update gives read-first behaviour on a same-address write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      rd_q <= '0;
      else if (rd_acc || rd_issue)   rd_q <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         addr       <= '0;
         remaining  <= '0;
         issue_left <= '0;
         rd_pend    <= 1'b0;
         rd_valid   <= 1'b0;
         data_hold  <= '0;
         s_ready    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done     <= 1'b0;
         rd_valid <= rd_acc;
         rd_pend  <= rd_issue;
         if (rd_valid) data_hold <= rd_q;
         err <= (burst_start && ((state != IDLE) || !len_ok)) ||
                ((wr_en || rd_en) && busy);
         case (state)
            IDLE: begin
               if (burst_start && len_ok) begin
                  addr       <= burst_base;
                  remaining  <= burst_len;
                  issue_left <= burst_len;
                  busy       <= 1'b1;
                  if (burst_dir == DIR_READ) begin
                     state <= RBURST;
                  end else begin
                     state   <= WBURST;
                     s_ready <= 1'b1;
                  end
               end
            end
            WBURST: begin
               if (wbeat) begin
                  addr      <= addr + ADDR_BITS'(1);
                  remaining <= remaining - LW'(1);
                  if (remaining == LW'(1)) begin
                     state   <= DONE;
                     s_ready <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            RBURST: begin
               if (rd_issue) begin
                  addr       <= addr + ADDR_BITS'(1);
                  issue_left <= issue_left - LW'(1);
               end
               // Reads never exceed the burst length, so the final accept leaves the buffer empty.
               if (pop) begin
                  remaining <= remaining - LW'(1);
                  if (remaining == LW'(1)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   gbuff_skid2 #(
      .DATA_BITS(DATA_BITS)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (rd_pend),
      .in_data  (rd_q),
      .out_valid(m_valid),
      .out_data (m_data),
      .out_ready(m_ready),
      .count    (buf_count)
   );

endmodule

// File: tb/tb_gbuff_burst.sv
// Directed self-checking bench for gbuff_burst: random access, bursts, rejects and reset.
module tb_gbuff_burst;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, rd_en;
   logic [3:0]  byte_en;
   logic [7:0]  index;
   logic [31:0] data_in, data_out;
   logic        rd_valid;
   logic        burst_start, burst_dir;
   logic [7:0]  burst_base;
   logic [8:0]  burst_len;
   logic        s_valid, s_ready;
   logic [31:0] s_data;
   logic        m_valid, m_ready;
   logic [31:0] m_data;
   logic        busy, done, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gbuff_burst dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .byte_en(byte_en), .rd_en(rd_en),
      .index(index), .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid),
      .burst_start(burst_start), .burst_dir(burst_dir), .burst_base(burst_base),
      .burst_len(burst_len), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .busy(busy), .done(done), .err(err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b expected 00", done, err); end
      checks++; if (s_ready !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL reset_stream: got %b%b expected 00", s_ready, m_valid); end
      checks++; if (rd_valid !== 1'b0 || data_out !== 32'h0 || m_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %b %h %h expected 0 0 0", rd_valid, data_out, m_data); end
      rst = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
   endtask

   task automatic test_byte_mask();
      wr_en = 1'b1; index = 8'd5; data_in = 32'hAABBCCDD; byte_en = 4'b1111;
      tick();
      data_in = 32'h11223344; byte_en = 4'b0101;
      tick();
      wr_en = 1'b0; byte_en = 4'b0000; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      checks++; if (rd_valid !== 1'b1 || data_out !== 32'hAA22CC44) begin errors++; $display("FAIL byte_mask: got %b %h expected 1 aa22cc44", rd_valid, data_out); end
      tick();
      checks++; if (rd_valid !== 1'b0 || data_out !== 32'hAA22CC44) begin errors++; $display("FAIL data_out_hold: got %b %h expected 0 aa22cc44", rd_valid, data_out); end
   endtask

   task automatic test_collision();
      wr_en = 1'b1; byte_en = 4'hF; index = 8'd3; data_in = 32'h1;
      tick();
      rd_en = 1'b1; data_in = 32'h2;
      tick();
      wr_en = 1'b0;
      checks++; if (rd_valid !== 1'b1 || data_out !== 32'h1) begin errors++; $display("FAIL collision_read_first: got %b %h expected 1 00000001", rd_valid, data_out); end
      tick();
      rd_en = 1'b0;
      checks++; if (data_out !== 32'h2) begin errors++; $display("FAIL collision_write_done: got %h expected 00000002", data_out); end
   endtask

   task automatic test_wrap_write();
      int beat = 0;
      logic [7:0] addrs [4] = '{8'd254, 8'd255, 8'd0, 8'd1};
      burst_start = 1'b1; burst_dir = 1'b0; burst_base = 8'd254; burst_len = 9'd4;
      tick();
      burst_start = 1'b0;
      checks++; if (busy !== 1'b1 || s_ready !== 1'b1) begin errors++; $display("FAIL wburst_enter: got %b%b expected 11", busy, s_ready); end
      for (int c = 0; c < 20 && beat < 4; c++) begin
         s_valid = (c % 3 != 1);
         s_data  = 32'h10 + 32'(beat);
         tick();
         if (s_valid) beat++;
         checks++;
         if (done !== (beat == 4)) begin errors++; $display("FAIL wburst_done_timing: got %b expected %b at beat %0d", done, beat == 4, beat); end
      end
      s_valid = 1'b0;
      checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL wburst_exit: got %b%b expected 00", busy, s_ready); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL wburst_done_pulse: got %b expected 0", done); end
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         index = addrs[i];
         tick();
         checks++;
         if (data_out !== 32'h10 + 32'(i)) begin errors++; $display("FAIL wrap_word_%0d: got %h expected %h", i, data_out, 32'h10 + 32'(i)); end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_read_burst();
      int k = 0;
      bit stalled = 1'b0;
      bit seen_done = 1'b0;
      logic [31:0] held = '0;
      logic [31:0] exp_d [4] = '{32'h10, 32'h11, 32'h12, 32'h13};
      burst_start = 1'b1; burst_dir = 1'b1; burst_base = 8'd254; burst_len = 9'd4;
      tick();
      burst_start = 1'b0;
      checks++; if (busy !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL rburst_enter: got %b%b expected 10", busy, s_ready); end
      for (int c = 0; c < 40; c++) begin
         if (done === 1'b1) begin seen_done = 1'b1; break; end
         if (stalled) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== held) begin errors++; $display("FAIL rburst_stall_stable: got %b %h expected 1 %h", m_valid, m_data, held); end
         end
         m_ready = (c % 4 == 0) || (c % 4 == 3);
         stalled = 1'b0;
         if (m_valid === 1'b1) begin
            if (m_ready) begin
               checks++;
               if (k > 3) begin errors++; $display("FAIL rburst_extra_beat: got %h expected none", m_data); end
               else if (m_data !== exp_d[k]) begin errors++; $display("FAIL rburst_beat_%0d: got %h expected %h", k, m_data, exp_d[k]); end
               k++;
            end else begin
               stalled = 1'b1;
               held = m_data;
            end
         end
         tick();
      end
      m_ready = 1'b0;
      checks++; if (!seen_done || k != 4) begin errors++; $display("FAIL rburst_done: got done=%0d beats=%0d expected 1 4", seen_done, k); end
      checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rburst_exit: got %b%b expected 00", m_valid, busy); end
      tick();
   endtask

   task automatic test_rejects();
      burst_start = 1'b1; burst_dir = 1'b0; burst_base = 8'd10; burst_len = 9'd0;
      tick();
      burst_start = 1'b0;
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reject_len0: got err=%b busy=%b expected 1 0", err, busy); end
      tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b expected 0", err); end
      burst_start = 1'b1; burst_len = 9'd2;
      tick();
      burst_start = 1'b0;
      rd_en = 1'b1; index = 8'd5;
      tick();
      rd_en = 1'b0;
      checks++; if (err !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL reject_rd_busy: got err=%b rd_valid=%b expected 1 0", err, rd_valid); end
      burst_start = 1'b1; burst_dir = 1'b1; burst_len = 9'd3;
      tick();
      burst_start = 1'b0;
      checks++; if (err !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b1) begin errors++; $display("FAIL reject_start_busy: got %b%b%b expected 111", err, busy, s_ready); end
      s_valid = 1'b1; s_data = 32'hA0;
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reject_burst_early_done: got %b expected 0", done); end
      s_data = 32'hA1;
      tick();
      s_valid = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL reject_burst_done: got %b expected 1", done); end
      rd_en = 1'b1; index = 8'd10;
      tick();
      checks++; if (data_out !== 32'hA0) begin errors++; $display("FAIL reject_burst_word0: got %h expected 000000a0", data_out); end
      index = 8'd11;
      tick();
      rd_en = 1'b0;
      checks++; if (data_out !== 32'hA1) begin errors++; $display("FAIL reject_burst_word1: got %h expected 000000a1", data_out); end
   endtask

   task automatic test_reset_mid_burst();
      burst_start = 1'b1; burst_dir = 1'b0; burst_base = 8'd20; burst_len = 9'd4;
      tick();
      burst_start = 1'b0;
      s_valid = 1'b1; s_data = 32'hB0;
      tick();
      s_data = 32'hB1;
      tick();
      s_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL async_reset_ctrl: got %b%b%b%b expected 0000", busy, s_ready, done, err); end
      checks++; if (data_out !== 32'h0 || m_data !== 32'h0 || m_valid !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL async_reset_data: got %h %h %b %b expected 0 0 0 0", data_out, m_data, m_valid, rd_valid); end
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL reset_abort_idle: got %b%b%b expected 000", done, busy, s_ready); end
      end
      rd_en = 1'b1; index = 8'd20;
      tick();
      checks++; if (data_out !== 32'hB0) begin errors++; $display("FAIL reset_kept_word0: got %h expected 000000b0", data_out); end
      index = 8'd21;
      tick();
      rd_en = 1'b0;
      checks++; if (data_out !== 32'hB1) begin errors++; $display("FAIL reset_kept_word1: got %h expected 000000b1", data_out); end
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; byte_en = '0; index = '0; data_in = '0;
      burst_start = 1'b0; burst_dir = 1'b0; burst_base = '0; burst_len = '0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      test_reset();
      test_byte_mask();
      test_collision();
      test_wrap_write();
      test_read_burst();
      test_rejects();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
